// File: rtl/fir_sample_sequencer.sv
// Sample FIFO and launch/capture sequencer in front of a single-multiplier FIR stage.
// Optional output decimation is compiled in with `define FIR_SEQ_DECIM_EN.
module fir_sample_sequencer #(
  parameter int BIT_WIDTH       = 16,
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter int TIMEOUT_CYCLES  = 1023,
  parameter int DECIM_FACTOR    = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BIT_WIDTH-1:0] ADC_DATA,
  input  logic                 ADC_VALID,
  output logic [BIT_WIDTH-1:0] FIR_DATA_IN,
  output logic                 FIR_START,
  input  logic                 FIR_RDY,
  input  logic [BIT_WIDTH-1:0] FIR_DATA_OUT,
  output logic [BIT_WIDTH-1:0] DOUT,
  output logic                 DOUT_VALID,
  output logic [15:0]          OVF_CNT,
  output logic                 TIMEOUT_ERR,
  output logic                 BUSY
);

  // state       | meaning
  // S_IDLE      | waiting for a queued sample and an idle filter
  // S_LAUNCH    | FIR_START high for this single cycle, watchdog cleared
  // S_WAIT_BUSY | waiting for the filter to drop FIR_RDY
  // S_WAIT_DONE | waiting for the filter to raise FIR_RDY again
  // S_EMIT      | result presented on DOUT (DOUT_VALID high if not decimated away)
  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_EMIT
  } state_t;

`ifdef FIR_SEQ_DECIM_EN
  localparam bit DECIM_EN = 1'b1;
`else
  localparam bit DECIM_EN = 1'b0;
`endif

  localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
  localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DECIM_N = DECIM_EN ? DECIM_FACTOR : 1;
  localparam int DEC_W   = $clog2(DECIM_N + 1);

  localparam logic [FIFO_DEPTH_LOG2:0] FIFO_FULL_CNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [WD_W-1:0]          WD_LAST       = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DEC_W-1:0]         DECIM_LAST    = DEC_W'(DECIM_N - 1);

  state_t                     state;
  logic [BIT_WIDTH-1:0]       fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   fifo_cnt;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic                       pop;
  logic                       push;
  logic                       drop;

  logic [BIT_WIDTH-1:0]       hold_q;
  logic                       start_q;
  logic [BIT_WIDTH-1:0]       dout_q;
  logic                       dout_valid_q;
  logic [15:0]                ovf_q;
  logic                       timeout_q;
  logic [WD_W-1:0]            wd_cnt;
  logic [DEC_W-1:0]           decim_cnt;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
  // Pop is decided from the registered count, so a fresh push is only visible next cycle.
  assign pop        = (state == S_IDLE) && !fifo_empty && FIR_RDY;
  assign push       = ADC_VALID && (!fifo_full || pop);
  assign drop       = ADC_VALID && fifo_full && !pop;

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= ADC_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      ovf_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (drop && (ovf_q != 16'hFFFF)) begin
        ovf_q <= ovf_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      hold_q       <= '0;
      start_q      <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      wd_cnt       <= '0;
      decim_cnt    <= '0;
    end else begin
      start_q      <= 1'b0;
      dout_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            hold_q  <= fifo_mem[rd_ptr];
            start_q <= 1'b1;
            state   <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          wd_cnt <= '0;
          state  <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!FIR_RDY) begin
            wd_cnt <= wd_cnt + 1'b1;
            state  <= S_WAIT_DONE;
          end else if (wd_cnt >= WD_LAST) begin
            timeout_q <= 1'b1;
            state     <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (FIR_RDY) begin
            state <= S_EMIT;
            // Every run advances the decimator; only the last phase reaches DOUT.
            if (decim_cnt == DECIM_LAST) begin
              dout_q       <= FIR_DATA_OUT;
              dout_valid_q <= 1'b1;
              decim_cnt    <= '0;
            end else begin
              decim_cnt <= decim_cnt + 1'b1;
            end
          end else if (wd_cnt >= WD_LAST) begin
            timeout_q <= 1'b1;
            state     <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_EMIT: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign FIR_DATA_IN = hold_q;
  assign FIR_START   = start_q;
  assign DOUT        = dout_q;
  assign DOUT_VALID  = dout_valid_q;
  assign OVF_CNT     = ovf_q;
  assign TIMEOUT_ERR = timeout_q;
  assign BUSY        = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Directed bench for fir_sample_sequencer with a behavioural filter (busy 20 cycles, result = input + 1).
module tb_fir_sample_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] ADC_DATA = '0;
  logic        ADC_VALID = 1'b0;
  logic [15:0] FIR_DATA_IN;
  logic        FIR_START;
  logic        FIR_RDY = 1'b1;
  logic [15:0] FIR_DATA_OUT = '0;
  logic [15:0] DOUT;
  logic        DOUT_VALID;
  logic [15:0] OVF_CNT;
  logic        TIMEOUT_ERR;
  logic        BUSY;

  fir_sample_sequencer #(
    .BIT_WIDTH(16), .FIFO_DEPTH_LOG2(3), .TIMEOUT_CYCLES(1023), .DECIM_FACTOR(4)
  ) dut (
    .CLK(CLK), .RST(RST), .ADC_DATA(ADC_DATA), .ADC_VALID(ADC_VALID),
    .FIR_DATA_IN(FIR_DATA_IN), .FIR_START(FIR_START), .FIR_RDY(FIR_RDY),
    .FIR_DATA_OUT(FIR_DATA_OUT), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID),
    .OVF_CNT(OVF_CNT), .TIMEOUT_ERR(TIMEOUT_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // filter model and output monitor, both evaluated mid-cycle
  int          start_cnt = 0;
  int          dout_cnt = 0;
  int          stab_err = 0;
  int          busy_cnt = 0;
  int          last_start_cyc = 0;
  int          last_rdy_cyc = 0;
  int          last_dv_cyc = 0;
  bit          model_busy = 1'b0;
  bit          hang_mode = 1'b0;
  bit          stab_en = 1'b0;
  logic [15:0] held = '0;
  logic [15:0] start_q[$];
  logic [15:0] dout_q[$];

  always @(negedge CLK) begin
    if (stab_en && model_busy && (FIR_DATA_IN !== held)) stab_err++;
    if (FIR_START === 1'b1) begin
      start_cnt++;
      start_q.push_back(FIR_DATA_IN);
      last_start_cyc = cyc;
      held = FIR_DATA_IN;
      if (!hang_mode) begin
        FIR_RDY = 1'b0;
        FIR_DATA_OUT = FIR_DATA_IN + 16'd1;
        busy_cnt = 20;
        model_busy = 1'b1;
      end
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        FIR_RDY = 1'b1;
        model_busy = 1'b0;
        last_rdy_cyc = cyc;
      end
    end
    if (DOUT_VALID === 1'b1) begin
      dout_cnt++;
      dout_q.push_back(DOUT);
      last_dv_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send(input logic [15:0] d);
    ADC_DATA = d;
    ADC_VALID = 1'b1;
    @(negedge CLK);
    ADC_VALID = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (!(BUSY === 1'b0 && busy_cnt == 0) && k < budget) begin
      @(negedge CLK);
      k++;
    end
    n_cmp++;
    if (!(BUSY === 1'b0 && busy_cnt == 0)) begin
      n_mis++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic wait_douts(input int target, input int budget, input string name);
    int k = 0;
    while (dout_cnt < target && k < budget) begin
      @(negedge CLK);
      k++;
    end
    n_cmp++;
    if (dout_cnt < target) begin
      n_mis++;
      $display("FAIL %s: %0d strobes seen, required %0d", name, dout_cnt, target);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_cmp++;
    if ({FIR_DATA_IN, FIR_START, DOUT, DOUT_VALID, OVF_CNT, TIMEOUT_ERR, BUSY} !== '0) begin
      n_mis++;
      $display("FAIL %s: din=%h start=%b dout=%h dv=%b ovf=%h terr=%b busy=%b, required all 0",
               name, FIR_DATA_IN, FIR_START, DOUT, DOUT_VALID, OVF_CNT, TIMEOUT_ERR, BUSY);
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    ADC_VALID = 1'b0;
    tick(3);
    check_all_zero("reset_held");
    RST = 1'b0;
    tick(2);
    check_all_zero("reset_released");
  endtask

  task automatic test_single;
    int s0 = start_cnt;
    int d0 = dout_cnt;
    int vcyc;
    int k = 0;
    stab_en = 1'b1;
    vcyc = cyc;
    send(16'h0100);
    while (start_cnt == s0 && k < 10) begin
      @(negedge CLK);
      k++;
    end
    n_cmp++;
    if (start_cnt != s0 + 1 || last_start_cyc - vcyc != 2) begin
      n_mis++;
      $display("FAIL single_latency: starts=%0d lat=%0d, required 1 start at latency 2",
               start_cnt - s0, last_start_cyc - vcyc);
    end
    n_cmp++;
    if (start_q[s0] !== 16'h0100) begin
      n_mis++;
      $display("FAIL single_din: got %h, required 0100", start_q[s0]);
    end
    wait_douts(d0 + 1, 60, "single_dout_wait");
    n_cmp++;
    if (dout_q[d0] !== 16'h0101) begin
      n_mis++;
      $display("FAIL single_dout: got %h, required 0101", dout_q[d0]);
    end
    n_cmp++;
    if (last_dv_cyc - last_rdy_cyc != 1) begin
      n_mis++;
      $display("FAIL single_dv_latency: got %0d, required 1", last_dv_cyc - last_rdy_cyc);
    end
    tick(10);
    n_cmp++;
    if (DOUT !== 16'h0101 || DOUT_VALID !== 1'b0 || dout_cnt != d0 + 1 || start_cnt != s0 + 1) begin
      n_mis++;
      $display("FAIL single_hold: dout=%h dv=%b strobes=%0d starts=%0d, required 0101/0/1/1",
               DOUT, DOUT_VALID, dout_cnt - d0, start_cnt - s0);
    end
    n_cmp++;
    if (stab_err != 0) begin
      n_mis++;
      $display("FAIL single_stable: %0d changes of FIR_DATA_IN during run, required 0", stab_err);
    end
  endtask

  task automatic test_burst8;
    logic [15:0] tbl [8];
    logic [15:0] exp_v;
    int s0 = start_cnt;
    int d0 = dout_cnt;
    tbl = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h1234, 16'hABCD, 16'h0001, 16'hFFFE};
    for (int i = 0; i < 8; i++) send(tbl[i]);
    wait_douts(d0 + 8, 400, "burst8_wait");
    for (int i = 0; i < 8; i++) begin
      exp_v = tbl[i] + 16'd1;
      n_cmp++;
      if (start_q[s0 + i] !== tbl[i] || dout_q[d0 + i] !== exp_v) begin
        n_mis++;
        $display("FAIL burst8_item%0d: din=%h dout=%h, required din=%h dout=%h",
                 i, start_q[s0 + i], dout_q[d0 + i], tbl[i], exp_v);
      end
    end
    n_cmp++;
    if (OVF_CNT !== 16'd0 || stab_err != 0) begin
      n_mis++;
      $display("FAIL burst8_ovf: ovf=%0d unstable=%0d, required 0/0", OVF_CNT, stab_err);
    end
  endtask

  task automatic test_burst12;
    logic [15:0] exp_v;
    int d0 = dout_cnt;
    for (int i = 0; i < 12; i++) send(16'h2000 + 16'(i));
    wait_douts(d0 + 9, 500, "burst12_wait");
    tick(40);
    n_cmp++;
    if (dout_cnt != d0 + 9 || OVF_CNT !== 16'd3) begin
      n_mis++;
      $display("FAIL burst12_count: strobes=%0d ovf=%0d, required 9/3", dout_cnt - d0, OVF_CNT);
    end
    for (int i = 0; i < 9; i++) begin
      exp_v = 16'h2001 + 16'(i);
      n_cmp++;
      if (dout_q[d0 + i] !== exp_v) begin
        n_mis++;
        $display("FAIL burst12_item%0d: got %h, required %h", i, dout_q[d0 + i], exp_v);
      end
    end
  endtask

  task automatic test_timeout;
    int s0 = start_cnt;
    int d0;
    int k = 0;
    wait_idle(100, "timeout_pre_idle");
    d0 = dout_cnt;
    hang_mode = 1'b1;
    send(16'h0A00);
    while (start_cnt == s0 && k < 10) begin
      @(negedge CLK);
      k++;
    end
    tick(1000 - (cyc - last_start_cyc));
    n_cmp++;
    if (TIMEOUT_ERR !== 1'b0 || BUSY !== 1'b1) begin
      n_mis++;
      $display("FAIL timeout_early: terr=%b busy=%b, required 0/1", TIMEOUT_ERR, BUSY);
    end
    tick(30);
    n_cmp++;
    if (TIMEOUT_ERR !== 1'b1 || BUSY !== 1'b0 || dout_cnt != d0) begin
      n_mis++;
      $display("FAIL timeout_set: terr=%b busy=%b strobes=%0d, required 1/0/0",
               TIMEOUT_ERR, BUSY, dout_cnt - d0);
    end
    hang_mode = 1'b0;
    send(16'h0B00);
    wait_douts(d0 + 1, 60, "timeout_next_wait");
    n_cmp++;
    if (dout_q[d0] !== 16'h0B01 || TIMEOUT_ERR !== 1'b1) begin
      n_mis++;
      $display("FAIL timeout_next: dout=%h terr=%b, required 0B01/1", dout_q[d0], TIMEOUT_ERR);
    end
  endtask

  task automatic test_reset_mid_run;
    int s0;
    int d0;
    wait_idle(100, "midrst_pre_idle");
    for (int i = 0; i < 4; i++) send(16'h3000 + 16'(i));
    tick(12);
    n_cmp++;
    if (BUSY !== 1'b1 || FIR_RDY !== 1'b0) begin
      n_mis++;
      $display("FAIL midrst_running: busy=%b rdy=%b, required 1/0", BUSY, FIR_RDY);
    end
    stab_en = 1'b0;
    s0 = start_cnt;
    d0 = dout_cnt;
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    tick(1);
    check_all_zero("midrst_outputs");
    tick(60);
    n_cmp++;
    if (start_cnt != s0 || dout_cnt != d0 || BUSY !== 1'b0) begin
      n_mis++;
      $display("FAIL midrst_quiet: starts=%0d strobes=%0d busy=%b, required 0/0/0",
               start_cnt - s0, dout_cnt - d0, BUSY);
    end
  endtask

`ifdef FIR_SEQ_DECIM_EN
  task automatic test_decim;
    int s0 = start_cnt;
    int d0 = dout_cnt;
    for (int i = 0; i < 8; i++) send(16'h4001 + 16'(i));
    tick(5);
    wait_idle(400, "decim_wait");
    n_cmp++;
    if (start_cnt != s0 + 8 || dout_cnt != d0 + 2) begin
      n_mis++;
      $display("FAIL decim_count: starts=%0d strobes=%0d, required 8/2", start_cnt - s0, dout_cnt - d0);
    end
    n_cmp++;
    if (dout_q[d0] !== 16'h4005 || dout_q[d0 + 1] !== 16'h4009) begin
      n_mis++;
      $display("FAIL decim_values: got %h %h, required 4005 4009", dout_q[d0], dout_q[d0 + 1]);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef FIR_SEQ_DECIM_EN
    test_decim();
`else
    test_single();
    test_burst8();
    test_burst12();
    test_timeout();
    test_reset_mid_run();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
